// File: rtl/boot_pkg.sv
// boot_pkg: shared states, target encodings and store codes for mem_boot_loader
package boot_pkg;
    typedef enum logic [1:0] {LOAD, DRAIN, RUN, ERROR} state_t;
    localparam logic IMEM = 1'b0;
    localparam logic DMEM = 1'b1;
    localparam logic [2:0] ST_WORD = 3'b010;
    localparam logic [2:0] ST_DWORD = 3'b011;
endpackage

// File: rtl/boot_checksum.sv
// boot_checksum: running modular sum of load words, compared against an expected value
module boot_checksum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] expected,
    output logic              mismatch
);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_nx;

    assign sum_nx   = sum + data;
    assign mismatch = sum_nx != expected;

    // accumulate each accepted word; clearing takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sum <= '0;
        else if (clr) sum <= '0;
        else if (add) sum <= sum_nx;
    end
endmodule

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: streams a program image into imem/dmem, then hands dmem to the CPU; BOOT_CHECKSUM_EN adds image checksum verification
module mem_boot_loader
    import boot_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter bit              AUTO_INC  = 1'b0,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_tgt,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] chk_expected,
    output logic              cpu_reset,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_adr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [2:0]        dmem_store,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_adr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              boot_done,
    output logic              boot_err,
    output logic [CNT_W-1:0]  word_cnt
);
    localparam logic [2:0] ST_CODE = (DATA_W == 64) ? ST_DWORD : ST_WORD;

    state_t            state, state_nx;
    logic              accept, go_load, chk_bad, run;
    logic              wr_vld, wr_tgt;
    logic [ADDR_W-1:0] wr_adr, adr_nx;
    logic [DATA_W-1:0] wr_dat;

    assign run      = state == RUN;
    assign ld_ready = state == LOAD;
    assign accept   = ld_valid && ld_ready;
    assign go_load  = (state == RUN || state == ERROR) && boot_req;
    assign adr_nx   = AUTO_INC ? BASE_ADDR + (ADDR_W'(word_cnt) << $clog2(DATA_W / 8)) : ld_addr;

`ifdef BOOT_CHECKSUM_EN
    logic mismatch;
    boot_checksum #(.DATA_W(DATA_W)) u_checksum (
        .clk      (clk),
        .reset    (reset),
        .clr      (go_load),
        .add      (accept),
        .data     (ld_data),
        .expected (chk_expected),
        .mismatch (mismatch)
    );
    assign chk_bad  = ld_last && mismatch;
    assign boot_err = state == ERROR;
`else
    logic unused_chk;
    assign unused_chk = ^chk_expected;
    assign chk_bad    = 1'b0;
    assign boot_err   = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else state <= state_nx;
    end

    // next state: last beat leaves LOAD, DRAIN lasts one cycle, boot_req reloads
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = (accept && ld_last) ? (chk_bad ? ERROR : DRAIN) : LOAD;
            DRAIN:   state_nx = RUN;
            default: state_nx = boot_req ? LOAD : state;
        endcase
    end

    // one-entry write register: each accepted beat is written the following cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_vld <= 1'b0;
            wr_tgt <= IMEM;
            wr_adr <= '0;
            wr_dat <= '0;
        end else begin
            wr_vld <= accept;
            if (accept) begin
                wr_tgt <= ld_tgt;
                wr_adr <= adr_nx;
                wr_dat <= ld_data;
            end
        end
    end

    // saturating beat counter, cleared when a reload starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) word_cnt <= '0;
        else if (go_load) word_cnt <= '0;
        else if (accept && !(&word_cnt)) word_cnt <= word_cnt + 1'b1;
    end

    assign cpu_reset  = !run;
    assign boot_done  = run;
    assign imem_we    = wr_vld && wr_tgt == IMEM;
    assign imem_adr   = wr_adr;
    assign imem_wdata = wr_dat;
    assign dmem_we    = run ? cpu_memwrite : wr_vld && wr_tgt == DMEM;
    assign dmem_adr   = run ? cpu_adr : wr_adr;
    assign dmem_wdata = run ? cpu_wdata : wr_dat;
    assign dmem_store = run ? cpu_funct3 : ST_CODE;
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: scoreboard bench driving an auto-increment and a manual-address loader in lockstep
module tb_mem_boot_loader;
    logic        clk = 1'b0;
    logic        reset, boot_req, ld_valid, ld_tgt, ld_last, cpu_memwrite;
    logic [31:0] ld_data, ld_addr, chk_expected, cpu_adr, cpu_wdata;
    logic [2:0]  cpu_funct3;

    logic        ld_ready_a, cpu_reset_a, dmem_we_a, imem_we_a, boot_done_a, boot_err_a;
    logic [31:0] dmem_adr_a, dmem_wdata_a, imem_adr_a, imem_wdata_a;
    logic [2:0]  dmem_store_a;
    logic [15:0] word_cnt_a;
    logic        ld_ready_m, cpu_reset_m, dmem_we_m, imem_we_m, boot_done_m, boot_err_m;
    logic [31:0] dmem_adr_m, dmem_wdata_m, imem_adr_m, imem_wdata_m;
    logic [2:0]  dmem_store_m;
    logic [15:0] word_cnt_m;

    typedef struct {
        logic        tgt;
        logic [31:0] aa;
        logic [31:0] am;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0, cyc = 0, cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_boot_loader #(.AUTO_INC(1'b1), .BASE_ADDR(32'h100)) u_a (
        .clk(clk), .reset(reset), .boot_req(boot_req), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
        .ld_data(ld_data), .ld_addr(ld_addr), .ld_tgt(ld_tgt), .ld_last(ld_last),
        .chk_expected(chk_expected), .cpu_reset(cpu_reset_a), .cpu_memwrite(cpu_memwrite),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .dmem_we(dmem_we_a),
        .dmem_adr(dmem_adr_a), .dmem_wdata(dmem_wdata_a), .dmem_store(dmem_store_a),
        .imem_we(imem_we_a), .imem_adr(imem_adr_a), .imem_wdata(imem_wdata_a),
        .boot_done(boot_done_a), .boot_err(boot_err_a), .word_cnt(word_cnt_a)
    );

    mem_boot_loader #(.AUTO_INC(1'b0)) u_m (
        .clk(clk), .reset(reset), .boot_req(boot_req), .ld_valid(ld_valid), .ld_ready(ld_ready_m),
        .ld_data(ld_data), .ld_addr(ld_addr), .ld_tgt(ld_tgt), .ld_last(ld_last),
        .chk_expected(chk_expected), .cpu_reset(cpu_reset_m), .cpu_memwrite(cpu_memwrite),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .dmem_we(dmem_we_m),
        .dmem_adr(dmem_adr_m), .dmem_wdata(dmem_wdata_m), .dmem_store(dmem_store_m),
        .imem_we(imem_we_m), .imem_adr(imem_adr_m), .imem_wdata(imem_wdata_m),
        .boot_done(boot_done_m), .boot_err(boot_err_m), .word_cnt(word_cnt_m)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one beat for a single cycle; it is accepted at the next edge and written the cycle after
    task automatic beat(input logic tgt, input logic [31:0] adr, input logic [31:0] dat, input logic last);
        exp_t e;
        ld_valid = 1'b1;
        ld_tgt   = tgt;
        ld_addr  = adr;
        ld_data  = dat;
        ld_last  = last;
        e.tgt = tgt;
        e.aa  = 32'h100 + 32'(cnt) * 4;
        e.am  = adr;
        e.d   = dat;
        e.c   = cyc + 1;
        q.push_back(e);
        cnt++;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic reset_vals(input string n);
        chk({n, "_cpu_reset"}, {cpu_reset_a, cpu_reset_m}, 2'b11);
        chk({n, "_ld_ready"}, {ld_ready_a, ld_ready_m}, 2'b11);
        chk({n, "_we"}, {imem_we_a, dmem_we_a, imem_we_m, dmem_we_m}, 4'b0);
        chk({n, "_flags"}, {boot_done_a, boot_err_a, boot_done_m, boot_err_m}, 4'b0);
        chk({n, "_word_cnt"}, {word_cnt_a, word_cnt_m}, 32'h0);
        chk({n, "_adr"}, {imem_adr_a, dmem_adr_a}, 64'h0);
        chk({n, "_wdata"}, {imem_wdata_m, dmem_wdata_m}, 64'h0);
    endtask

    // monitor: every loader write must match the oldest expected beat, in the expected cycle
    always @(negedge clk) begin
        if (reset && cpu_reset_a && (imem_we_a || dmem_we_a || imem_we_m || dmem_we_m)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: imem_we=%0b dmem_we=%0b expected none (cycle %0d)",
                         imem_we_a, dmem_we_a, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(e.c));
                chk("we_a", {imem_we_a, dmem_we_a}, e.tgt ? 2'b01 : 2'b10);
                chk("we_m", {imem_we_m, dmem_we_m}, e.tgt ? 2'b01 : 2'b10);
                chk("adr_a", e.tgt ? dmem_adr_a : imem_adr_a, e.aa);
                chk("adr_m", e.tgt ? dmem_adr_m : imem_adr_m, e.am);
                chk("data_a", e.tgt ? dmem_wdata_a : imem_wdata_a, e.d);
                chk("data_m", e.tgt ? dmem_wdata_m : imem_wdata_m, e.d);
                if (e.tgt) chk("dmem_store", dmem_store_a, 3'b010);
            end
        end
    end

    initial begin
        reset = 1'b0; boot_req = 1'b0; ld_valid = 1'b0; ld_tgt = 1'b0; ld_last = 1'b0;
        ld_data = '0; ld_addr = '0; chk_expected = '0;
        cpu_memwrite = 1'b0; cpu_adr = '0; cpu_wdata = '0; cpu_funct3 = '0;
        tick();
        tick();
        reset_vals("por");
        reset = 1'b1;
        tick();

        // three imem beats back to back with auto-increment addresses
        cnt = 0;
        beat(1'b0, 32'h0, 32'h11, 1'b0);
        beat(1'b0, 32'h4, 32'h22, 1'b0);
        beat(1'b0, 32'h8, 32'h33, 1'b1);
        chk("drain_cnt", word_cnt_a, 16'd3);
        chk("drain_cpu_reset", cpu_reset_a, 1'b1);
        chk("drain_ready", ld_ready_a, 1'b0);
        tick();
        chk("run_cpu_reset", {cpu_reset_a, cpu_reset_m}, 2'b00);
        chk("run_done", {boot_done_a, boot_done_m}, 2'b11);
        chk("run_imem_we", imem_we_a, 1'b0);

        // CPU owns dmem combinationally; a beat offered now must be held
        cpu_memwrite = 1'b1; cpu_adr = 32'h80; cpu_wdata = 32'hA5A5_0001; cpu_funct3 = 3'b001;
        ld_valid = 1'b1; ld_tgt = 1'b1; ld_addr = 32'h40; ld_data = 32'hDEADBEEF;
        #1;
        chk("cpu_we", dmem_we_a, 1'b1);
        chk("cpu_adr", dmem_adr_a, 32'h80);
        chk("cpu_wdata", dmem_wdata_m, 32'hA5A5_0001);
        chk("cpu_store", dmem_store_a, 3'b001);
        tick();
        chk("run_hold_ready", ld_ready_a, 1'b0);
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        chk("reload_cpu_reset", cpu_reset_a, 1'b1);
        chk("reload_cnt", word_cnt_a, 16'd0);
        chk("reload_cut_cpu", dmem_we_a, 1'b0);
        cpu_memwrite = 1'b0;

        // alternating targets with gaps; the held dmem beat goes first
        cnt = 0;
        beat(1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
        beat(1'b0, 32'h44, 32'h0000_1234, 1'b0);
        tick();
        tick();
        beat(1'b1, 32'h48, 32'hCAFE_F00D, 1'b0);
        tick();
        beat(1'b0, 32'h4C, 32'h0BAD_F00D, 1'b1);
        chk("gap_cnt", {word_cnt_a, word_cnt_m}, {16'd4, 16'd4});
        tick();
        chk("gap_run", boot_done_a, 1'b1);

        // asynchronous reset with one beat in the write register and another offered
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        cnt = 0;
        beat(1'b0, 32'h50, 32'h77, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h54; ld_data = 32'h88;
        reset = 1'b0;
        void'(q.pop_back());
        #1;
        reset_vals("async");
        tick();
        tick();
        ld_valid = 1'b0;
        reset = 1'b1;
        chk("post_reset_cnt", word_cnt_a, 16'd0);

        // image 1,2,3 against expected sum 7, then 6
        cnt = 0;
        chk_expected = 32'd7;
        beat(1'b1, 32'h0, 32'd1, 1'b0);
        beat(1'b1, 32'h4, 32'd2, 1'b0);
        beat(1'b1, 32'h8, 32'd3, 1'b1);
        tick();
`ifdef BOOT_CHECKSUM_EN
        chk("err_flag", {boot_err_a, boot_err_m}, 2'b11);
        chk("err_cpu_reset", cpu_reset_a, 1'b1);
        chk("err_done", boot_done_a, 1'b0);
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        chk("err_reload", {boot_err_a, ld_ready_a, word_cnt_a}, {2'b01, 16'd0});
        cnt = 0;
        chk_expected = 32'd6;
        beat(1'b1, 32'h0, 32'd1, 1'b0);
        beat(1'b1, 32'h4, 32'd2, 1'b0);
        beat(1'b1, 32'h8, 32'd3, 1'b1);
        tick();
`endif
        chk("final_run", {boot_done_a, boot_err_a, cpu_reset_a}, 3'b100);
        tick();
        tick();
        chk("all_writes_seen", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_boot_loader.md
# mem_boot_loader

Parametrised program loader and memory-port arbiter placed between the `riscv_cpu` core and its instruction and data memories. After reset it holds the core in reset and accepts a valid/ready stream of words, writing each into instruction or data memory. On the last beat it releases the core and hands the data-memory write port to the CPU. A later `boot_req` reloads the memories without a global reset.

## Interface
Parameters:
- `DATA_W`, default 32. Memory word width; legal values are 32 and 64.
- `ADDR_W`, default 32. Byte-address width.
- `AUTO_INC`, default 0.
  - 1: the write address is generated internally and `ld_addr` is ignored.
  - 0: the write address is `ld_addr`.
- `BASE_ADDR`, default 0. First address used when `AUTO_INC` = 1.
- `CNT_W`, default 16. Width of the word counter.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `boot_req`  in  1  reload request; honoured in RUN and ERROR only.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  loader accepts a beat.
- `ld_data`  in  DATA_W  load word.
- `ld_addr`  in  ADDR_W  byte address, word-aligned.
- `ld_tgt`  in  1  destination: 0 = instruction memory, 1 = data memory.
- `ld_last`  in  1  final beat of the image.
- `chk_expected`  in  DATA_W  expected checksum (see Configuration).
- `cpu_reset`  out  1  active-high reset to `riscv_cpu`.
- `cpu_memwrite`  in  1  CPU data write enable.
- `cpu_adr`  in  ADDR_W  CPU data address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_funct3`  in  3  CPU store type.
- `dmem_we`  out  1  data memory write enable.
- `dmem_adr`  out  ADDR_W  data memory address.
- `dmem_wdata`  out  DATA_W  data memory write data.
- `dmem_store`  out  3  data memory store type.
- `imem_we`  out  1  instruction memory write enable.
- `imem_adr`  out  ADDR_W  instruction memory address.
- `imem_wdata`  out  DATA_W  instruction memory write data.
- `boot_done`  out  1  high in RUN.
- `boot_err`  out  1  high in ERROR.
- `word_cnt`  out  CNT_W  beats accepted in the current load.

## Operation
- States: LOAD, DRAIN, RUN, ERROR.
- LOAD
  - `ld_ready` = 1 and `cpu_reset` = 1.
  - A beat is accepted when `ld_valid` and `ld_ready` are both 1 at a rising edge.
  - The accepted beat is captured into a one-entry write register: valid bit, target, address, data.
- Write stage
  - When the write register is valid, the selected memory sees its write enable high for exactly one cycle.
  - `imem_wdata` or `dmem_wdata` carries the captured data.
  - `dmem_store` = 3'b010 when `DATA_W` = 32, and 3'b011 when `DATA_W` = 64.
- Address generation
  - `AUTO_INC` = 1: address = `BASE_ADDR` + `word_cnt`·(DATA_W/8). A single counter is shared by both targets.
  - `AUTO_INC` = 0: address = `ld_addr`. Low address bits are passed through unchecked.
- `word_cnt` increments per accepted beat, saturates at all-ones, and clears on entry to LOAD.
- Leaving LOAD
  - Accepted beat with `ld_last` = 1 → DRAIN.
  - With `BOOT_CHECKSUM_EN` and a checksum mismatch → ERROR instead.
- DRAIN: `ld_ready` = 0; the final write is performed; next state RUN.
- RUN
  - `cpu_reset` = 0, `boot_done` = 1, `ld_ready` = 0.
  - `imem_we` = 0.
  - The dmem port is combinationally muxed from the `cpu_*` inputs.
  - `boot_req` = 1 → LOAD, with `cpu_reset` = 1 from the next cycle.
- ERROR
  - `cpu_reset` = 1, `boot_err` = 1, `ld_ready` = 0.
  - `boot_req` → LOAD.
- `boot_req` in LOAD or DRAIN is ignored.
- `ld_valid` outside LOAD is not accepted; the stream must hold the beat.

## Timing
- Reset values (`reset` = 0):
  - State = LOAD; `cpu_reset` = 1; `ld_ready` = 1.
  - `imem_we` = `dmem_we` = 0; `boot_done` = `boot_err` = 0; `word_cnt` = 0.
  - All address and data outputs = 0; write register invalid; checksum = 0.
- Write latency: a beat accepted at edge N is written during cycle N+1 and committed at edge N+1.
- Throughput: one beat per cycle in LOAD.
- Last beat accepted at edge N:
  - DRAIN during cycle N+1.
  - RUN from edge N+1.
  - `cpu_reset` falls in cycle N+2.
- `boot_req` sampled in RUN at edge M: state LOAD and `cpu_reset` = 1 from cycle M+1. CPU stores are cut off in the same cycle.
- Reset asserted mid-load: state and outputs take their reset values asynchronously. A pending write is discarded; memory contents are left partial.

## Configuration
- `BOOT_CHECKSUM_EN` defined
  - A running sum (mod 2^DATA_W) of every accepted `ld_data`, including the last beat, is compared against `chk_expected` sampled with the last beat.
  - On a mismatch the final write is still performed, and the state goes to ERROR instead of DRAIN.
  - The sum clears on entry to LOAD.
- `BOOT_CHECKSUM_EN` not defined
  - No checksum logic; `chk_expected` is ignored.
  - `boot_err` is tied to 0 and ERROR is unreachable.

## Structure
- Package `boot_pkg` holds:
  - the state enum (LOAD, DRAIN, RUN, ERROR);
  - the target encodings IMEM = 0, DMEM = 1;
  - the store codes `ST_WORD` = 3'b010 and `ST_DWORD` = 3'b011.
- Sub-module `boot_checksum` (accumulator with clear, add, and compare) is instantiated only under `BOOT_CHECKSUM_EN`.

## Test plan
- Load three beats with `AUTO_INC` = 1, `BASE_ADDR` = 0x100 and data 0x11, 0x22, 0x33 (last) to imem:
  - `imem_we` is high for three consecutive cycles at addresses 0x100, 0x104, 0x108;
  - `word_cnt` = 3;
  - `cpu_reset` falls two cycles after the last beat.
- Load with `ld_tgt` alternating and `AUTO_INC` = 0:
  - dmem beat to 0x40 with data 0xDEADBEEF gives `dmem_we` = 1, `dmem_store` = 3'b010;
  - no `imem_we` in that cycle.
- Drive `ld_valid` with gaps, including a held beat:
  - no beat is lost or duplicated;
  - `word_cnt` equals the number of accepted beats.
- In RUN, set `cpu_memwrite` = 1 with `cpu_adr` = 0x80: `dmem_we` = 1 and `dmem_adr` = 0x80 in the same cycle. Then pulse `boot_req`: `cpu_reset` = 1 and `word_cnt` = 0 the next cycle.
- Assert `reset` while two beats are pending: all outputs return to their reset values immediately and no write occurs.
- With `BOOT_CHECKSUM_EN`, load 1, 2, 3 with `chk_expected` = 7:
  - result is ERROR, `boot_err` = 1, `cpu_reset` stays 1;
  - `boot_req` returns the block to LOAD;
  - reloading with `chk_expected` = 6 reaches RUN.
